// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer: decodes a 16-bit instruction once in P2, holds the
// controls, and issues phase-qualified strobes with a memory wait/timeout in P4.
module phase_sequencer #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15,
    parameter int MEM_WAIT_EN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             exec,
    input  logic             step,
    input  logic [15:0]      command,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic [4:0]       phase,
    output logic             ir_we,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             reg_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             sw_re,
    output logic [1:0]       led_we,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic [2:0]       ALUSrc,
    output logic [3:0]       ALUOp,
    output logic             running,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] insn_count
);

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_P1, S_P2, S_P3, S_P4, S_P5, S_HALTED
    } state_t;

    typedef struct packed {
        logic       regDst;
        logic       memtoReg;
        logic [2:0] aluSrc;
        logic [3:0] aluOp;
        logic       isLd;
        logic       isSt;
        logic       regWr;
        logic       isBr;
        logic       isBrCond;
        logic       isIn;
        logic       isHalt;
        logic [1:0] led;
    } ctl_t;

    state_t           state_q, state_d;
    ctl_t             ctl_q, ctl_d, ctlDec;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [1:0] op1;
    logic [2:0] op2;
    logic [3:0] op3;
    logic [3:0] dField;
    logic       unusedCmdBits;

    assign op1           = command[15:14];
    assign op2           = command[13:11];
    assign op3           = command[7:4];
    assign dField        = command[3:0];
    assign unusedCmdBits = ^command[10:8];

    always_comb begin
        ctlDec = '0;
        unique case (op1)
            2'b00: begin
                ctlDec.aluSrc   = 3'b001;
                ctlDec.isLd     = 1'b1;
                ctlDec.regWr    = 1'b1;
                ctlDec.memtoReg = 1'b1;
            end
            2'b01: begin
                ctlDec.aluSrc = 3'b001;
                ctlDec.isSt   = 1'b1;
            end
            2'b10: begin
                ctlDec.aluSrc = 3'b010;
                case (op2)
                    3'b000: begin
                        ctlDec.regWr  = 1'b1;
                        ctlDec.regDst = 1'b1;
                    end
                    3'b100:  ctlDec.isBr     = 1'b1;
                    3'b111:  ctlDec.isBrCond = 1'b1;
                    default: ;
                endcase
            end
            default: begin
                case (op3)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110: begin
                        ctlDec.aluOp  = op3;
                        ctlDec.regWr  = 1'b1;
                        ctlDec.regDst = 1'b1;
                    end
                    4'b0101: ctlDec.aluOp = 4'b0101;
                    4'b0111: begin
                        ctlDec.aluSrc = 3'b100;
                        ctlDec.regWr  = 1'b1;
                    end
                    4'b1110: begin
                        ctlDec.aluSrc = 3'b100;
                        ctlDec.aluOp  = 4'b0001;
                        ctlDec.regWr  = 1'b1;
                    end
                    4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
                        ctlDec.aluSrc = 3'b001;
                        ctlDec.aluOp  = op3;
                        ctlDec.regWr  = 1'b1;
                        ctlDec.regDst = 1'b1;
                    end
                    4'b1100: begin
                        ctlDec.isIn     = 1'b1;
                        ctlDec.regWr    = 1'b1;
                        ctlDec.memtoReg = 1'b1;
                        ctlDec.regDst   = 1'b1;
                    end
                    4'b1101: begin
                        ctlDec.aluSrc = 3'b101;
                        ctlDec.aluOp  = 4'b0110;
                        ctlDec.led    = (dField == 4'd0) ? 2'b10 : 2'b11;
                    end
                    default: ctlDec.isHalt = 1'b1;
                endcase
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ctl_q     <= '0;
            waitCnt_q <= '0;
            fault_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            ctl_q     <= ctl_d;
            waitCnt_q <= waitCnt_d;
            fault_q   <= fault_d;
            count_q   <= count_d;
        end
    end

    // The wait counter only survives consecutive P4 cycles without mem_ready.
    always_comb begin
        state_d   = state_q;
        ctl_d     = ctl_q;
        waitCnt_d = '0;
        fault_d   = fault_q;
        count_d   = count_q;
        phase     = 5'b00000;
        ir_we     = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        reg_we    = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        sw_re     = 1'b0;
        led_we    = 2'b00;
        unique case (state_q)
            S_IDLE: begin
                if (exec) state_d = S_P1;
            end
            S_HALTED: begin
                if (exec) begin
                    state_d = S_P1;
                    fault_d = 1'b0;
                end
            end
            S_P1: begin
                phase   = 5'b00001;
                ir_we   = 1'b1;
                pc_inc  = 1'b1;
                state_d = S_P2;
            end
            S_P2: begin
                phase   = 5'b00010;
                ctl_d   = ctlDec;
                state_d = S_P3;
            end
            S_P3: begin
                phase   = 5'b00100;
                state_d = S_P4;
            end
            S_P4: begin
                phase  = 5'b01000;
                mem_re = ctl_q.isLd;
                mem_we = ctl_q.isSt;
                if (!(ctl_q.isLd || ctl_q.isSt) || MEM_WAIT_EN == 0 || mem_ready) begin
                    state_d = S_P5;
                end else begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                    if (MEM_TIMEOUT != 0 && waitCnt_d == TIMEOUT_V) begin
                        state_d = S_HALTED;
                        fault_d = 1'b1;
                    end
                end
            end
            S_P5: begin
                phase   = 5'b10000;
                reg_we  = ctl_q.regWr;
                pc_load = ctl_q.isBr || (ctl_q.isBrCond && br_taken);
                sw_re   = ctl_q.isIn;
                led_we  = ctl_q.led;
                count_d = count_q + CNT_W'(1);
                if (ctl_q.isHalt)  state_d = S_HALTED;
                else if (step)     state_d = S_IDLE;
                else               state_d = S_P1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign RegDst     = ctl_q.regDst;
    assign MemtoReg   = ctl_q.memtoReg;
    assign ALUSrc     = ctl_q.aluSrc;
    assign ALUOp      = ctl_q.aluOp;
    assign running    = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted     = (state_q == S_HALTED);
    assign fault      = fault_q;
    assign insn_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: a vector table of single-stepped instructions scored at P5,
// plus hand-written sequences for halt, memory timeout and reset during a P4 wait.
module tb_phase_sequencer;

    logic        clock = 1'b0;
    logic        reset, exec, step, mem_ready, br_taken;
    logic [15:0] command;
    logic [4:0]  phase;
    logic        ir_we, pc_inc, pc_load, reg_we, mem_re, mem_we, sw_re;
    logic [1:0]  led_we;
    logic        RegDst, MemtoReg;
    logic [2:0]  ALUSrc;
    logic [3:0]  ALUOp;
    logic        running, halted, fault;
    logic [15:0] insn_count;

    phase_sequencer #(.CNT_W(16), .MEM_TIMEOUT(4), .MEM_WAIT_EN(1)) dut (
        .clock(clock), .reset(reset), .exec(exec), .step(step), .command(command),
        .mem_ready(mem_ready), .br_taken(br_taken), .phase(phase), .ir_we(ir_we),
        .pc_inc(pc_inc), .pc_load(pc_load), .reg_we(reg_we), .mem_re(mem_re),
        .mem_we(mem_we), .sw_re(sw_re), .led_we(led_we), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .running(running),
        .halted(halted), .fault(fault), .insn_count(insn_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] cmd;
        logic        br;
        int          readyAt;
        logic        regWe, pcLoad, swRe, memtoReg, regDst;
        logic [1:0]  led;
        logic [2:0]  aluSrc;
        logic [3:0]  aluOp;
        int          cycles, memRe, memWe;
    } vec_t;

    vec_t        vecs[16];
    vec_t        haltVec;
    vec_t        expQ[$];
    logic [15:0] cmdQ[$];
    int checks = 0;
    int errors = 0;
    int expCount = 0;
    int runCycles, memReCnt, memWeCnt, regWeCnt, p4Cnt, p5Cnt, p1Cnt, pcIncCnt, violations;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        exec = 1'b1;
        @(posedge clock);
        #1 exec = 1'b0;
        #1;
    endtask

    task automatic scoreP5();
        vec_t e;
        if (expQ.size() == 0) begin
            checkOutput("unexpected P5", 32'(1), 32'(0));
            return;
        end
        e = expQ.pop_front();
        checkOutput($sformatf("%h reg_we", e.cmd), 32'(reg_we), 32'(e.regWe));
        checkOutput($sformatf("%h pc_load", e.cmd), 32'(pc_load), 32'(e.pcLoad));
        checkOutput($sformatf("%h sw_re", e.cmd), 32'(sw_re), 32'(e.swRe));
        checkOutput($sformatf("%h led_we", e.cmd), 32'(led_we), 32'(e.led));
        checkOutput($sformatf("%h MemtoReg", e.cmd), 32'(MemtoReg), 32'(e.memtoReg));
        checkOutput($sformatf("%h RegDst", e.cmd), 32'(RegDst), 32'(e.regDst));
        checkOutput($sformatf("%h ALUSrc", e.cmd), 32'(ALUSrc), 32'(e.aluSrc));
        checkOutput($sformatf("%h ALUOp", e.cmd), 32'(ALUOp), 32'(e.aluOp));
    endtask

    // Walks the DUT cycle by cycle until it leaves P1..P5, driving mem_ready on the
    // readyAt-th P4 cycle (0 = never) and tallying strobes per phase.
    task automatic runUntilStop(input int readyAt, input int budget);
        int p4Idx = 0;
        runCycles = 0; memReCnt = 0; memWeCnt = 0; regWeCnt = 0; p4Cnt = 0;
        p5Cnt = 0; p1Cnt = 0; pcIncCnt = 0; violations = 0;
        for (int c = 0; c < budget; c++) begin
            if (phase == 5'b01000) begin
                p4Idx++;
                mem_ready = (readyAt != 0 && p4Idx >= readyAt);
            end else begin
                p4Idx = 0;
                mem_ready = 1'b0;
            end
            #1;
            if (!running) return;
            runCycles++;
            memReCnt += int'(mem_re);
            memWeCnt += int'(mem_we);
            regWeCnt += int'(reg_we);
            if ((ir_we || pc_inc) && phase != 5'b00001) violations++;
            if ((mem_re || mem_we) && phase != 5'b01000) violations++;
            if ((reg_we || pc_load || sw_re || led_we != 2'b00) && phase != 5'b10000) violations++;
            if (phase == 5'b00001) begin
                p1Cnt++;
                if (ir_we && pc_inc) pcIncCnt++;
            end
            if (phase == 5'b01000) p4Cnt++;
            if (phase == 5'b10000) begin
                p5Cnt++;
                scoreP5();
                if (cmdQ.size() != 0) command = cmdQ.pop_front();
            end
            @(posedge clock);
            #1;
        end
        checkOutput("run budget expired", 32'(running), 32'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        //              cmd     br rdy regWe pcL swRe m2r dst led    src     op    cyc mRe mWe
        vecs[0]  = '{16'h0000, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b001, 4'h0, 7, 3, 0};
        vecs[1]  = '{16'hC050, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 4'h5, 5, 0, 0};
        vecs[2]  = '{16'hC0D0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 3'b101, 4'h6, 5, 0, 0};
        vecs[3]  = '{16'hC0D3, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b101, 4'h6, 5, 0, 0};
        vecs[4]  = '{16'hB800, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 4'h0, 5, 0, 0};
        vecs[5]  = '{16'hB800, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 4'h0, 5, 0, 0};
        vecs[6]  = '{16'hA000, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 4'h0, 5, 0, 0};
        vecs[7]  = '{16'h8000, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b010, 4'h0, 5, 0, 0};
        vecs[8]  = '{16'hC000, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 4'h0, 5, 0, 0};
        vecs[9]  = '{16'hC070, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b100, 4'h0, 5, 0, 0};
        vecs[10] = '{16'hC0E0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b100, 4'h1, 5, 0, 0};
        vecs[11] = '{16'hC090, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b001, 4'h9, 5, 0, 0};
        vecs[12] = '{16'hC0C0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 3'b000, 4'h0, 5, 0, 0};
        vecs[13] = '{16'h4000, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b001, 4'h0, 5, 0, 1};
        vecs[14] = '{16'h9000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 4'h0, 5, 0, 0};
        vecs[15] = '{16'hC060, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 4'h6, 5, 0, 0};
        haltVec  = '{16'hC0F0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 4'h0, 5, 0, 0};

        reset = 1'b1; exec = 1'b0; step = 1'b1; mem_ready = 1'b0; br_taken = 1'b0; command = 16'h0000;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset phase", 32'(phase), 32'(0));
        checkOutput("reset running", 32'(running), 32'(0));
        checkOutput("reset halted", 32'(halted), 32'(0));
        checkOutput("reset fault", 32'(fault), 32'(0));
        checkOutput("reset insn_count", 32'(insn_count), 32'(0));
        checkOutput("reset strobes", 32'({ir_we, pc_inc, pc_load, reg_we, mem_re, mem_we, sw_re, led_we}), 32'(0));
        checkOutput("reset controls", 32'({RegDst, MemtoReg, ALUSrc, ALUOp}), 32'(0));
        reset = 1'b0;
        #1;

        for (int i = 0; i < 16; i++) begin
            command = vecs[i].cmd;
            br_taken = vecs[i].br;
            expQ.push_back(vecs[i]);
            applyStimulus();
            runUntilStop(vecs[i].readyAt, 30);
            expCount++;
            checkOutput($sformatf("v%0d cycles", i), 32'(runCycles), 32'(vecs[i].cycles));
            checkOutput($sformatf("v%0d mem_re cycles", i), 32'(memReCnt), 32'(vecs[i].memRe));
            checkOutput($sformatf("v%0d mem_we cycles", i), 32'(memWeCnt), 32'(vecs[i].memWe));
            checkOutput($sformatf("v%0d insn_count", i), 32'(insn_count), 32'(expCount));
            checkOutput($sformatf("v%0d phase violations", i), 32'(violations), 32'(0));
            checkOutput($sformatf("v%0d pc_inc in P1", i), 32'(pcIncCnt), 32'(p1Cnt));
            checkOutput($sformatf("v%0d P5 scored", i), 32'(expQ.size()), 32'(0));
            checkOutput($sformatf("v%0d idle after step", i), 32'({running, halted}), 32'(0));
        end

        // CMP followed by HALT without single-step: two retirements, then HALTED.
        step = 1'b0;
        br_taken = 1'b0;
        command = 16'hC050;
        cmdQ.push_back(16'hC0F0);
        expQ.push_back(vecs[1]);
        expQ.push_back(haltVec);
        applyStimulus();
        runUntilStop(0, 40);
        expCount += 2;
        checkOutput("cmp/halt reg_we count", 32'(regWeCnt), 32'(0));
        checkOutput("cmp/halt P5 count", 32'(p5Cnt), 32'(2));
        checkOutput("cmp/halt cycles", 32'(runCycles), 32'(10));
        checkOutput("cmp/halt halted", 32'(halted), 32'(1));
        checkOutput("cmp/halt fault", 32'(fault), 32'(0));
        checkOutput("cmp/halt insn_count", 32'(insn_count), 32'(expCount));
        checkOutput("cmp/halt P5 scored", 32'(expQ.size()), 32'(0));

        // Store with mem_ready stuck low times out after four P4 cycles.
        step = 1'b1;
        command = 16'h4000;
        applyStimulus();
        runUntilStop(0, 30);
        checkOutput("timeout P4 cycles", 32'(p4Cnt), 32'(4));
        checkOutput("timeout mem_we cycles", 32'(memWeCnt), 32'(4));
        checkOutput("timeout P5 count", 32'(p5Cnt), 32'(0));
        checkOutput("timeout halted", 32'(halted), 32'(1));
        checkOutput("timeout fault", 32'(fault), 32'(1));
        checkOutput("timeout insn_count", 32'(insn_count), 32'(expCount));

        command = 16'hC0F0;
        expQ.push_back(haltVec);
        applyStimulus();
        checkOutput("resume fault", 32'(fault), 32'(0));
        checkOutput("resume phase", 32'(phase), 32'(5'b00001));
        runUntilStop(0, 30);
        expCount++;
        checkOutput("resume insn_count", 32'(insn_count), 32'(expCount));
        checkOutput("resume halted", 32'(halted), 32'(1));

        // Reset while a load is waiting in P4.
        command = 16'h0000;
        mem_ready = 1'b0;
        applyStimulus();
        for (int c = 0; c < 10 && phase != 5'b01000; c++) begin
            @(posedge clock);
            #2;
        end
        checkOutput("reached P4", 32'(phase), 32'(5'b01000));
        @(posedge clock);
        #2;
        checkOutput("P4 wait mem_re", 32'(mem_re), 32'(1));
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("midP4 reset phase", 32'(phase), 32'(0));
        checkOutput("midP4 reset mem_re", 32'(mem_re), 32'(0));
        checkOutput("midP4 reset insn_count", 32'(insn_count), 32'(0));
        checkOutput("midP4 reset status", 32'({running, halted, fault}), 32'(0));
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("idle after reset", 32'(phase), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Multi-cycle successor to the purely combinational instruction decoder.
- Owns the five-phase instruction cycle (fetch, decode, execute, memory, write-back), decodes the 16-bit instruction once and holds the decoded controls for the whole instruction.
- Emits single-cycle, phase-qualified write/read strobes to the PC, IR, register file, data memory, LED and switch paths.
- Adds what the old decoder lacked: a memory wait handshake with timeout, single-step mode, a halted/fault state and a retired-instruction counter.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- MEM_TIMEOUT, 15, maximum P4 wait cycles; 0 disables the timeout.
- MEM_WAIT_EN, 1, 1 = P4 waits for mem_ready; 0 = P4 always lasts one cycle.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- exec  in  1  start/resume pulse.
- step  in  1  1 = stop in IDLE after each retired instruction.
- command  in  16  instruction word from instruction memory (IR input).
- mem_ready  in  1  data memory access complete.
- br_taken  in  1  condition result for conditional branch (op2=111).
- phase  out  5  one-hot P1..P5; 0 when not running.
- ir_we  out  1  IR load strobe.
- pc_inc  out  1  PC+1 strobe.
- pc_load  out  1  PC branch-load strobe.
- reg_we  out  1  register file write strobe.
- mem_re, mem_we  out  1 each  data memory read / write.
- sw_re  out  1  switch input sample strobe.
- led_we  out  2  bit1 = output enable, bit0 = output with address.
- RegDst, MemtoReg  out  1 each  held decoded controls.
- ALUSrc  out  3  held decoded control.
- ALUOp  out  4  held decoded control.
- running, halted, fault  out  1 each  status.
- insn_count  out  CNT_W  instructions retired.

Behaviour:
- Clock and reset: single clock `clock`. Reset is synchronous, active-high, port `reset`.
- Reset values: state=IDLE, every output 0, insn_count 0, wait counter 0. Reset is applied from any state, including mid-P4 wait.
- States: IDLE, P1, P2, P3, P4, P5, HALTED. `running`=1 in P1..P5; `halted`=1 in HALTED.
- IDLE: exec=1 -> P1.
- HALTED: exec=1 -> P1 and clears fault.
- P1..P5: exec is ignored.
- P1: ir_we=1, pc_inc=1 for one cycle -> P2.
- P2: decode `command` and register the decoded controls; they hold until the next P2 or reset -> P3.
- Decode fields: op1=[15:14], op2=[13:11], op3=[7:4], d=[3:0].
- Decode, op1=00 LD: ALUSrc 001, ALUOp 0000, mem_re in P4, reg_we in P5, MemtoReg 1, RegDst 0.
- Decode, op1=01 ST: ALUSrc 001, ALUOp 0000, mem_we in P4.
- Decode, op1=10: ALUSrc 010, ALUOp 0000.
  - op2=000 LI: reg_we, RegDst 1.
  - op2=100 B: pc_load in P5.
  - op2=111 BC: pc_load in P5 iff br_taken sampled in P5.
  - Other op2: no effect.
- Decode, op1=11, by op3:
  - 0000-0100, 0110: ALUSrc 000, ALUOp=op3, reg_we, RegDst 1.
  - 0101 CMP: ALUSrc 000, ALUOp 0101, no write.
  - 0111 ADDI: ALUSrc 100, ALUOp 0000, reg_we, RegDst 0.
  - 1110 SUBI: ALUSrc 100, ALUOp 0001, reg_we, RegDst 0.
  - 1000-1011 shifts: ALUSrc 001, ALUOp=op3, reg_we, RegDst 1.
  - 1100 IN: sw_re in P5, reg_we, MemtoReg 1, RegDst 1.
  - 1101 OUT: ALUSrc 101, ALUOp 0110, led_we in P5 = 10 if d==0, else 11.
  - 1111 HALT: no strobes.
- P3: no strobes -> P4.
- P4, non-memory instruction: one cycle.
- P4, memory instruction: mem_re/mem_we held high while in P4. Leave on the cycle mem_ready=1, or after one cycle if MEM_WAIT_EN=0.
- P4 timeout: the wait counter increments each P4 cycle without mem_ready. On reaching MEM_TIMEOUT (nonzero) -> HALTED with fault=1; no P5 strobes issue and insn_count does not increment.
- P5: write-back strobes for one cycle; insn_count increments, wrapping modulo 2^CNT_W.
- P5 exit:
  - HALT -> HALTED.
  - else step=1 -> IDLE.
  - else -> P1.
- Strobe exclusivity: strobes are never asserted outside their listed phase. At most one of reg_we/pc_load/led_we is active per instruction except IN (reg_we + sw_re).
- phase output: equals current state one-hot; 0 in IDLE/HALTED.

Test Plan:
- Reset mid-P4 wait with mem_ready=0 -> next cycle state IDLE, phase=0, mem_re=0, insn_count=0.
- exec, command=0x0000 (LD), mem_ready asserted 3 cycles into P4 -> mem_re high exactly 3 P4 cycles. reg_we=1, MemtoReg=1 in P5. insn_count=1. Instruction takes 7 cycles.
- command=0xC050 (CMP) then 0xC0F0 (HALT), step=0 -> reg_we never asserted. HALTED after second P5. insn_count=2. halted=1.
- command=0xC0D0 then 0xC0D3 (OUT) -> led_we=10 then 11, each one cycle in P5. ALUSrc=101.
- command=0xB800 (BC), br_taken=0 then 1 -> pc_load 0 then 1 in P5. pc_inc=1 in every P1.
- MEM_TIMEOUT=4, ST with mem_ready stuck 0 -> after 4 P4 cycles, HALTED with fault=1. Subsequent exec -> fault=0, state P1.
